floo_vc_output_scheduler: RTL and testbench

FLOO_VC_OUTPUT_SCHEDULER -- requirements
Module: floo_vc_output_scheduler

---
 rtl/floo_vc_pkg.sv | 16 +
 rtl/rr_arb_tree.sv | 29 ++
 rtl/floo_vc_output_scheduler.sv | 139 +++++++++++++
 tb/tb_floo_vc_output_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/floo_vc_pkg.sv
// Shared types for the VC output scheduler.
// Holds the scheduler state enum and credit-counter width helper.
package floo_vc_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin arbiter with externally supplied priority pointer.
// The caller owns the pointer, so it can freeze it while locked.
module rr_arb_tree #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [IdxWidth-1:0] rr_i,
  input  logic [NumIn-1:0]    req_i,
  output logic [NumIn-1:0]    gnt_o
);

  logic        w_found;
  int unsigned w_k;

  // First requester at or after rr_i wins, wrapping around.
  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      w_k = (32'(rr_i) + i) % NumIn;
      if (!w_found && req_i[w_k]) begin
        gnt_o[w_k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_vc_output_scheduler.sv
// Credit-based VC output scheduler with wormhole packet lock.
// Define FLOO_VC_SCHED_CREDIT_BYPASS_EN for same-cycle credit bypass.
module floo_vc_output_scheduler
  import floo_vc_pkg::*;
#(
  parameter int unsigned NumVC      = 4,
  parameter int unsigned NumVCWidth = 2,
  parameter int unsigned VCDepth    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumVC-1:0]      req_vc_i,
  input  logic [NumVC-1:0]      last_i,
  output logic                  grant_v_o,
  output logic [NumVC-1:0]      grant_vc_oh_o,
  output logic [NumVCWidth-1:0] grant_vc_id_o,
  input  logic                  credit_v_i,
  input  logic [NumVCWidth-1:0] credit_id_i,
  output logic [NumVC-1:0]      credit_avail_o,
  output logic                  overflow_o
);

  localparam int unsigned CntW = cnt_width(VCDepth);
  localparam logic [CntW-1:0] FullCnt = CntW'(VCDepth);

  logic [NumVC-1:0][CntW-1:0] r_cnt;
  state_e                     r_state;
  logic [NumVCWidth-1:0]      r_lock_vc;
  logic [NumVCWidth-1:0]      r_rr_ptr;
  logic                       r_ovf;

  logic [NumVC-1:0]      w_avail;
  logic [NumVC-1:0]      w_cred_hit;
  logic [NumVC-1:0]      w_lock_oh;
  logic [NumVC-1:0]      w_elig;
  logic [NumVC-1:0]      w_req_arb;
  logic [NumVC-1:0]      w_gnt_arb;
  logic [NumVC-1:0]      w_gnt_oh;
  logic [NumVCWidth-1:0] w_gnt_id;
  logic [NumVCWidth-1:0] w_ptr_nxt;
  logic                  w_gnt_v;
  logic                  w_gnt_last;

  // Per-VC credit status, credit-return hit and lock mask.
  always_comb begin
    w_avail    = '0;
    w_cred_hit = '0;
    w_lock_oh  = '0;
    for (int v = 0; v < NumVC; v++) begin
      w_avail[v]    = r_cnt[v] != '0;
      w_cred_hit[v] = credit_v_i &&
                      credit_id_i == NumVCWidth'(v);
      w_lock_oh[v]  = r_lock_vc == NumVCWidth'(v);
    end
  end

`ifdef FLOO_VC_SCHED_CREDIT_BYPASS_EN
  assign w_elig = req_vc_i & (w_avail | w_cred_hit);
`else
  assign w_elig = req_vc_i & w_avail;
`endif

  // While locked only the owning VC may compete.
  always_comb begin
    w_req_arb = w_elig;
    if (r_state == LOCKED) w_req_arb = w_elig & w_lock_oh;
  end

  rr_arb_tree #(
    .NumIn    (NumVC),
    .IdxWidth (NumVCWidth)
  ) i_arb (
    .rr_i  (r_rr_ptr),
    .req_i (w_req_arb),
    .gnt_o (w_gnt_arb)
  );

  assign w_gnt_oh   = rst_ni ? w_gnt_arb : '0;
  assign w_gnt_v    = |w_gnt_oh;
  assign w_gnt_last = |(w_gnt_oh & last_i);

  // One-hot grant to binary index.
  always_comb begin
    w_gnt_id = '0;
    for (int v = 0; v < NumVC; v++) begin
      if (w_gnt_oh[v]) w_gnt_id = w_gnt_id | NumVCWidth'(v);
    end
  end

  assign w_ptr_nxt = (w_gnt_id == NumVCWidth'(NumVC - 1)) ?
                     '0 : w_gnt_id + 1'b1;

  assign grant_v_o      = w_gnt_v;
  assign grant_vc_oh_o  = w_gnt_oh;
  assign grant_vc_id_o  = w_gnt_id;
  assign credit_avail_o = w_avail;
  assign overflow_o     = r_ovf;

  // Packet lock FSM and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_lock_vc <= '0;
      r_rr_ptr  <= '0;
    end else if (w_gnt_v) begin
      case (r_state)
        IDLE: begin
          r_rr_ptr <= w_ptr_nxt;
          if (!w_gnt_last) begin
            r_state   <= LOCKED;
            r_lock_vc <= w_gnt_id;
          end
        end
        LOCKED: begin
          if (w_gnt_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Credit counters with saturation and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= {NumVC{FullCnt}};
      r_ovf <= 1'b0;
    end else begin
      for (int v = 0; v < NumVC; v++) begin
        if (w_gnt_oh[v] && !w_cred_hit[v]) begin
          r_cnt[v] <= r_cnt[v] - 1'b1;
        end else if (!w_gnt_oh[v] && w_cred_hit[v]) begin
          if (r_cnt[v] == FullCnt) r_ovf <= 1'b1;
          else r_cnt[v] <= r_cnt[v] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_floo_vc_output_scheduler.sv
// Directed bench for floo_vc_output_scheduler.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_floo_vc_output_scheduler;
  import floo_vc_pkg::*;

  logic       clk;
  logic       rst_ni;
  logic [3:0] req;
  logic [3:0] last;
  logic       gv;
  logic [3:0] goh;
  logic [1:0] gid;
  logic       cv;
  logic [1:0] cid;
  logic [3:0] avail;
  logic       ovf;

  int n_chk;
  int n_pass;
  logic byp;

  floo_vc_output_scheduler #(
    .NumVC      (4),
    .NumVCWidth (2),
    .VCDepth    (3)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_vc_i       (req),
    .last_i         (last),
    .grant_v_o      (gv),
    .grant_vc_oh_o  (goh),
    .grant_vc_id_o  (gid),
    .credit_v_i     (cv),
    .credit_id_i    (cid),
    .credit_avail_o (avail),
    .overflow_o     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic credit(input logic [1:0] id);
    cv  = 1'b1;
    cid = id;
    @(negedge clk);
    cv  = 1'b0;
  endtask

  task automatic chk_cnts(input string tag, input int exp);
    for (int v = 0; v < 4; v++)
      check(tag, 32'(dut.r_cnt[v]), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
`ifdef FLOO_VC_SCHED_CREDIT_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst_ni = 1'b0;
    req    = '0;
    last   = '0;
    cv     = 1'b0;
    cid    = '0;
    repeat (2) @(negedge clk);

    // reset holds grants low even with requests
    req  = 4'hF;
    last = 4'hF;
    #1;
    check("rst_gv", gv, 0);
    check("rst_oh", goh, 0);
    check("rst_id", gid, 0);
    check("rst_avail", avail, 4'hF);
    check("rst_ovf", ovf, 0);

    // round robin over single-flit packets
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gv", gv, 1);
      check("rr_id", gid, 32'(i));
      @(negedge clk);
    end
    req = '0;
    chk_cnts("rr_cnt", 2);
    for (int v = 0; v < 4; v++) credit(2'(v));
    chk_cnts("refill_cnt", 3);

    // VC1 packet lock: 4 flits, pointer frozen
    req  = 4'b0010;
    last = 4'b0000;
    #1;
    check("lk_head", gid, 1);
    @(negedge clk);
    req = 4'b1011;
    cv  = 1'b1;
    cid = 2'd1;
    #1;
    check("lk_b1_oh", goh, 4'b0010);
    @(negedge clk);
    cv = 1'b0;
    #1;
    check("lk_b2_id", gid, 1);
    @(negedge clk);
    last = 4'b0010;
    #1;
    check("lk_tail_id", gid, 1);
    @(negedge clk);
    check("lk_idle", dut.r_state, IDLE);
    check("lk_cnt1", 32'(dut.r_cnt[1]), 0);
    check("lk_avail", avail, 4'b1101);
    last = 4'b1011;
    #1;
    check("lk_after_id", gid, 3);
    @(negedge clk);
    req  = '0;
    last = '0;
    repeat (3) credit(2'd1);
    credit(2'd3);
    chk_cnts("lk_refill", 3);

    // exhaust VC2 then revive with one credit
    req  = 4'b0100;
    last = 4'b0100;
    repeat (3) begin
      #1;
      check("ex_id", gid, 2);
      @(negedge clk);
    end
    #1;
    check("ex_empty_gv", gv, 0);
    cv  = 1'b1;
    cid = 2'd2;
    #1;
    check("ex_cred_gv", gv, 32'(byp));
    @(negedge clk);
    cv = 1'b0;
    #1;
    check("ex_next_gv", gv, 32'(!byp));
    @(negedge clk);
    req = '0;
    check("ex_cnt2", 32'(dut.r_cnt[2]), 0);
    repeat (3) credit(2'd2);

    // grant and credit on VC0 together
    req  = 4'b0001;
    last = 4'b0001;
    cv   = 1'b1;
    cid  = 2'd0;
    #1;
    check("gc_id", gid, 0);
    check("gc_gv", gv, 1);
    @(negedge clk);
    cv  = 1'b0;
    req = '0;
    check("gc_cnt0", 32'(dut.r_cnt[0]), 3);
    check("gc_ovf", ovf, 0);

    // overflow on full VC3 is sticky
    credit(2'd3);
    check("ov_flag", ovf, 1);
    check("ov_cnt3", 32'(dut.r_cnt[3]), 3);
    @(negedge clk);
    check("ov_sticky", ovf, 1);

    // reset while LOCKED(2)
    req  = 4'b0100;
    last = 4'b0000;
    #1;
    check("rl_head", gid, 2);
    @(negedge clk);
    req = 4'b0101;
    #1;
    check("rl_oh", goh, 4'b0100);
    @(negedge clk);
    check("rl_locked", dut.r_state, LOCKED);
    rst_ni = 1'b0;
    req    = 4'hF;
    #1;
    check("rl_gv", gv, 0);
    check("rl_oh0", goh, 0);
    check("rl_idle", dut.r_state, IDLE);
    chk_cnts("rl_cnt", 3);
    check("rl_ovf", ovf, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    last   = 4'hF;
    #1;
    check("rl_post_id", gid, 0);
    check("rl_post_gv", gv, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
